oram_cmd_arbiter: RTL and testbench

//  Shares the single ORAM backend command port between two requesters:

---
 rtl/oram_cmd_arbiter_if.sv | 62 ++++++
 rtl/oram_cmd_arbiter.sv | 152 +++++++++++++++
 tb/tb_oram_cmd_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/oram_cmd_arbiter_if.sv
// Bundle of the requester, backend and status signals around oram_cmd_arbiter.
//
// Modports:
//   master - the arbiter's view: consumes both requester command ports and the
//            backend response pulse; drives the requester readies, the backend
//            command, the per-port response steering and the status flags.
//   slave  - the environment's view (requesters + backend), directions mirrored.
//
// Signals:
//   InCmdValid0/InCmd0/InAddr0/InCmdReady0  port 0 (instruction fetch) command
//   InCmdValid1/InCmd1/InAddr1/InCmdReady1  port 1 (data) command
//   OutCmdValid/OutCmd/OutAddr/OutCmdReady  backend command port
//   RespValid                               backend read-response pulse
//   RespValid0/RespValid1                   response steered to the issuing port
//   Busy/SpuriousResp/ErrTimeout            status
interface oram_cmd_arbiter_if #(
  parameter int unsigned CmdWidth  = 2,
  parameter int unsigned AddrWidth = 32
);
  logic                 InCmdValid0;
  logic [CmdWidth-1:0]  InCmd0;
  logic [AddrWidth-1:0] InAddr0;
  logic                 InCmdReady0;
  logic                 InCmdValid1;
  logic [CmdWidth-1:0]  InCmd1;
  logic [AddrWidth-1:0] InAddr1;
  logic                 InCmdReady1;
  logic                 OutCmdValid;
  logic [CmdWidth-1:0]  OutCmd;
  logic [AddrWidth-1:0] OutAddr;
  logic                 OutCmdReady;
  logic                 RespValid;
  logic                 RespValid0;
  logic                 RespValid1;
  logic                 Busy;
  logic                 SpuriousResp;
  logic                 ErrTimeout;

  modport master (
    input  InCmdValid0, InCmd0, InAddr0,
    output InCmdReady0,
    input  InCmdValid1, InCmd1, InAddr1,
    output InCmdReady1,
    output OutCmdValid, OutCmd, OutAddr,
    input  OutCmdReady,
    input  RespValid,
    output RespValid0, RespValid1,
    output Busy, SpuriousResp, ErrTimeout
  );

  modport slave (
    output InCmdValid0, InCmd0, InAddr0,
    input  InCmdReady0,
    output InCmdValid1, InCmd1, InAddr1,
    input  InCmdReady1,
    input  OutCmdValid, OutCmd, OutAddr,
    output OutCmdReady,
    output RespValid,
    input  RespValid0, RespValid1,
    input  Busy, SpuriousResp, ErrTimeout
  );
endinterface

// File: rtl/oram_cmd_arbiter.sv
// Two-port round-robin arbiter in front of the single ORAM backend command port.
// Port 0 is instruction fetch, port 1 is data. Exactly one transaction is in
// flight: a read blocks further issue until the backend response arrives, and
// that response is steered back to the port that issued it.
//
// Ports:
//   Clock    system clock
//   Reset_n  asynchronous reset, active-low
//   bus      oram_cmd_arbiter_if.master (requester ports, backend port, status)
//
// Optional feature: define ORAM_ARB_TIMEOUT_EN to add a response watchdog that
// abandons a read after TimeoutCycles cycles in the wait state and raises the
// sticky ErrTimeout flag. Without it ErrTimeout is tied low.
module oram_cmd_arbiter #(
  parameter int unsigned          CmdWidth      = 2,
  parameter int unsigned          AddrWidth     = 32,
  parameter logic [CmdWidth-1:0]  ReadCmd       = CmdWidth'(1),
  parameter int unsigned          TimeoutCycles = 1024
) (
  input logic                Clock,
  input logic                Reset_n,
  oram_cmd_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitResp} state_e;

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 rr_last_q, rr_last_d;
  logic [CmdWidth-1:0]  out_cmd_q, out_cmd_d;
  logic [AddrWidth-1:0] out_addr_q, out_addr_d;
  logic                 spurious_q, spurious_d;

  logic sel_valid;
  logic sel;
  logic is_read;
  logic resp_fwd;

`ifdef ORAM_ARB_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0] wait_cnt_q, wait_cnt_d;
  logic                err_timeout_q, err_timeout_d;
`endif

  // RRLast resets to 1 so that port 0 wins the first tie.
  assign sel_valid = bus.InCmdValid0 | bus.InCmdValid1;
  assign sel       = (bus.InCmdValid0 & bus.InCmdValid1) ? ~rr_last_q : bus.InCmdValid1;
  assign is_read   = (out_cmd_q == ReadCmd);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    out_cmd_d  = out_cmd_q;
    out_addr_d = out_addr_q;
    resp_fwd   = 1'b0;
`ifdef ORAM_ARB_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = err_timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          state_d    = StIssue;
          grant_d    = sel;
          rr_last_d  = sel;
          out_cmd_d  = sel ? bus.InCmd1  : bus.InCmd0;
          out_addr_d = sel ? bus.InAddr1 : bus.InAddr0;
        end
      end
      StIssue: begin
        if (bus.OutCmdReady) begin
          if (!is_read) begin
            state_d = StIdle;
          end else if (bus.RespValid) begin
            // Zero-latency backend: answer arrives with the accept.
            resp_fwd = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StWaitResp;
`ifdef ORAM_ARB_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
          end
        end
      end
      StWaitResp: begin
        if (bus.RespValid) begin
          resp_fwd = 1'b1;
          state_d  = StIdle;
        end else begin
`ifdef ORAM_ARB_TIMEOUT_EN
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_d == CntWidth'(TimeoutCycles)) begin
            err_timeout_d = 1'b1;
            state_d       = StIdle;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // Any response that is not steered to a port is unexpected.
    spurious_d = spurious_q | (bus.RespValid & ~resp_fwd);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      out_cmd_q  <= '0;
      out_addr_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_last_q  <= rr_last_d;
      out_cmd_q  <= out_cmd_d;
      out_addr_q <= out_addr_d;
      spurious_q <= spurious_d;
    end
  end

`ifdef ORAM_ARB_TIMEOUT_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end
  assign bus.ErrTimeout = err_timeout_q;
`else
  assign bus.ErrTimeout = 1'b0;
`endif

  assign bus.InCmdReady0  = (state_q == StIdle) & sel_valid & ~sel;
  assign bus.InCmdReady1  = (state_q == StIdle) & sel_valid & sel;
  assign bus.OutCmdValid  = (state_q == StIssue);
  assign bus.OutCmd       = out_cmd_q;
  assign bus.OutAddr      = out_addr_q;
  assign bus.RespValid0   = resp_fwd & ~grant_q;
  assign bus.RespValid1   = resp_fwd & grant_q;
  assign bus.Busy         = (state_q != StIdle);
  assign bus.SpuriousResp = spurious_q;

endmodule

// File: tb/tb_oram_cmd_arbiter.sv
module tb_oram_cmd_arbiter;
  localparam int unsigned CmdWidth      = 2;
  localparam int unsigned AddrWidth     = 32;
  localparam logic [1:0]  ReadCmd       = 2'd1;
  localparam int unsigned TimeoutCycles = 8;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  oram_cmd_arbiter_if #(.CmdWidth(CmdWidth), .AddrWidth(AddrWidth)) bus ();

  oram_cmd_arbiter #(
    .CmdWidth      (CmdWidth),
    .AddrWidth     (AddrWidth),
    .ReadCmd       (ReadCmd),
    .TimeoutCycles (TimeoutCycles)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v0;
    logic [1:0]  c0;
    logic [31:0] a0;
    logic        v1;
    logic [1:0]  c1;
    logic [31:0] a1;
    logic        ordy;
    logic        resp;
    logic [5:0]  flags;  // {rdy0, rdy1, outValid, resp0, resp1, busy}
    logic [1:0]  cmd;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic v0, logic [1:0] c0, logic [31:0] a0, logic v1,
                              logic [1:0] c1, logic [31:0] a1, logic ordy, logic resp,
                              logic [5:0] flags, logic [1:0] cmd, logic [31:0] addr);
    vec_t v;
    v.v0 = v0; v.c0 = c0; v.a0 = a0; v.v1 = v1; v.c1 = c1; v.a1 = a1;
    v.ordy = ordy; v.resp = resp; v.flags = flags; v.cmd = cmd; v.addr = addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance from one drive point (just after negedge) to the next.
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic idle_inputs();
    bus.InCmdValid0 = 1'b0; bus.InCmd0 = '0; bus.InAddr0 = '0;
    bus.InCmdValid1 = 1'b0; bus.InCmd1 = '0; bus.InAddr1 = '0;
    bus.OutCmdReady = 1'b0; bus.RespValid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset_n = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  function automatic logic [5:0] flags_now();
    return {bus.InCmdReady0, bus.InCmdReady1, bus.OutCmdValid,
            bus.RespValid0, bus.RespValid1, bus.Busy};
  endfunction

  // Transaction-level reference model state.
  bit          m_have, m_sent, m_port, m_prefer, m_spur, m_err;
  logic [1:0]  m_cmd;
  logic [31:0] m_addr;
  int          m_wait;

  initial begin
    int acc, last, gap_bad, resp_seen, n;
    idle_inputs();

    // Vector table, applied back-to-back from reset.
    vecs[0]  = mk(1, 2'd1, 32'h100, 1, 2'd1, 32'h200, 1, 0, 6'b100000, 2'd0, 32'h0);
    vecs[1]  = mk(1, 2'd1, 32'h100, 1, 2'd1, 32'h200, 1, 0, 6'b001001, 2'd1, 32'h100);
    vecs[2]  = mk(1, 2'd1, 32'h100, 1, 2'd1, 32'h200, 1, 0, 6'b000001, 2'd1, 32'h100);
    vecs[3]  = mk(1, 2'd1, 32'h100, 1, 2'd1, 32'h200, 1, 1, 6'b000101, 2'd1, 32'h100);
    vecs[4]  = mk(1, 2'd1, 32'h100, 1, 2'd1, 32'h200, 1, 0, 6'b010000, 2'd1, 32'h100);
    vecs[5]  = mk(1, 2'd1, 32'h100, 1, 2'd1, 32'h200, 1, 1, 6'b001011, 2'd1, 32'h200);
    vecs[6]  = mk(1, 2'd2, 32'h300, 1, 2'd1, 32'h200, 1, 0, 6'b100000, 2'd1, 32'h200);
    vecs[7]  = mk(1, 2'd2, 32'h300, 1, 2'd1, 32'h200, 0, 0, 6'b001001, 2'd2, 32'h300);
    vecs[8]  = mk(1, 2'd2, 32'h300, 1, 2'd1, 32'h200, 1, 0, 6'b001001, 2'd2, 32'h300);
    vecs[9]  = mk(0, 2'd2, 32'h300, 1, 2'd3, 32'h400, 1, 0, 6'b010000, 2'd2, 32'h300);
    vecs[10] = mk(0, 2'd2, 32'h300, 1, 2'd3, 32'h400, 1, 0, 6'b001001, 2'd3, 32'h400);
    vecs[11] = mk(0, 2'd2, 32'h300, 0, 2'd3, 32'h400, 1, 0, 6'b000000, 2'd3, 32'h400);

    do_reset();
    #1;
    check("reset", {flags_now(), bus.SpuriousResp, bus.ErrTimeout, bus.OutCmd, bus.OutAddr}, 0);

    for (int i = 0; i < 12; i++) begin
      bus.InCmdValid0 = vecs[i].v0; bus.InCmd0 = vecs[i].c0; bus.InAddr0 = vecs[i].a0;
      bus.InCmdValid1 = vecs[i].v1; bus.InCmd1 = vecs[i].c1; bus.InAddr1 = vecs[i].a1;
      bus.OutCmdReady = vecs[i].ordy; bus.RespValid = vecs[i].resp;
      #1;
      check($sformatf("vec%0d flags", i), flags_now(), vecs[i].flags);
      check($sformatf("vec%0d cmd", i), {bus.OutCmd, bus.OutAddr}, {vecs[i].cmd, vecs[i].addr});
      tick();
    end
    #1;
    check("no spurious after table", bus.SpuriousResp, 0);
    tick();

    // Port 1 streams writes with an always-ready backend.
    idle_inputs();
    bus.InCmdValid1 = 1'b1; bus.InCmd1 = 2'd2; bus.OutCmdReady = 1'b1;
    acc = 0; last = 0; gap_bad = 0; resp_seen = 0;
    for (int c = 0; c < 20; c++) begin
      bus.InAddr1 = 32'h1000 + c;
      #1;
      if (bus.InCmdReady1) begin
        if (acc > 0 && c - last != 2) gap_bad++;
        last = c;
        acc++;
      end
      if (bus.RespValid0 || bus.RespValid1 || bus.InCmdReady0) resp_seen++;
      tick();
    end
    check("stream accepts", acc, 10);
    check("stream gaps", gap_bad, 0);
    check("stream no resp", resp_seen, 0);

    // Response pulse while idle.
    idle_inputs();
    tick();
    bus.RespValid = 1'b1;
    #1;
    check("idle resp not forwarded", {bus.RespValid0, bus.RespValid1}, 0);
    tick();
    bus.RespValid = 1'b0;
    #1;
    check("spurious set", bus.SpuriousResp, 1);
    tick(); tick(); tick();
    #1;
    check("spurious sticky", bus.SpuriousResp, 1);

    // Reset while a port 0 read is outstanding.
    do_reset();
    bus.InCmdValid0 = 1'b1; bus.InCmd0 = 2'd1; bus.InAddr0 = 32'hABC;
    bus.InCmdValid1 = 1'b1; bus.InCmd1 = 2'd1; bus.InAddr1 = 32'hDEF;
    bus.OutCmdReady = 1'b1;
    tick();
    bus.InCmdValid0 = 1'b0; bus.InCmdValid1 = 1'b0;
    tick();
    #1;
    check("in wait before reset", {bus.Busy, bus.OutCmdValid}, 2'b10);
    bus.RespValid = 1'b1;
    Reset_n = 1'b0;
    #1;
    check("outputs zero in reset",
          {flags_now(), bus.SpuriousResp, bus.ErrTimeout, bus.OutCmd, bus.OutAddr}, 0);
    tick();
    bus.RespValid = 1'b0;
    Reset_n = 1'b1;
    bus.InCmdValid0 = 1'b1; bus.InCmdValid1 = 1'b1;
    #1;
    check("port0 wins tie after reset", {bus.InCmdReady0, bus.InCmdReady1}, 2'b10);
    bus.InCmdValid0 = 1'b0; bus.InCmdValid1 = 1'b0;
    bus.RespValid = 1'b1;
    #1;
    check("late resp not forwarded", {bus.RespValid0, bus.RespValid1}, 0);
    tick();
    bus.RespValid = 1'b0;
    #1;
    check("late resp spurious", bus.SpuriousResp, 1);

    // Read that never gets a response.
    do_reset();
    bus.InCmdValid0 = 1'b1; bus.InCmd0 = 2'd1; bus.InAddr0 = 32'h55; bus.OutCmdReady = 1'b1;
    tick();
    bus.InCmdValid0 = 1'b0;
    tick();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!bus.Busy) break;
      n++;
      tick();
    end
`ifdef ORAM_ARB_TIMEOUT_EN
    check("timeout wait cycles", n, TimeoutCycles);
    check("timeout flag", bus.ErrTimeout, 1);
    bus.InCmdValid1 = 1'b1; bus.InCmd1 = 2'd2;
    #1;
    check("grant after timeout", {bus.InCmdReady0, bus.InCmdReady1}, 2'b01);
    tick();
    idle_inputs();
    tick();
    tick();
`else
    check("wait indefinitely", n, 40);
    check("no timeout flag", bus.ErrTimeout, 0);
    bus.RespValid = 1'b1;
    #1;
    check("very late resp forwarded", {bus.RespValid0, bus.RespValid1}, 2'b10);
    tick();
    bus.RespValid = 1'b0;
`endif

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_have = 0; m_sent = 0; m_port = 0; m_prefer = 0; m_spur = 0; m_err = 0;
    m_cmd = '0; m_addr = '0; m_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        pick_ok, pick, deliver;
      logic [41:0] exp, act;
      bus.InCmdValid0 = 1'($urandom_range(0, 1));
      bus.InCmd0      = 2'($urandom_range(0, 3));
      bus.InAddr0     = $urandom;
      bus.InCmdValid1 = 1'($urandom_range(0, 1));
      bus.InCmd1      = 2'($urandom_range(0, 3));
      bus.InAddr1     = $urandom;
      bus.OutCmdReady = 1'($urandom_range(0, 2) != 0);
      bus.RespValid   = ($urandom_range(0, 4) == 0);
      #1;
      pick_ok = !m_have && (bus.InCmdValid0 || bus.InCmdValid1);
      pick    = (bus.InCmdValid0 && bus.InCmdValid1) ? m_prefer : bus.InCmdValid1;
      deliver = bus.RespValid && m_have && (m_cmd == ReadCmd) && (m_sent || bus.OutCmdReady);
      exp = {pick_ok && !pick, pick_ok && pick, m_have && !m_sent,
             deliver && !m_port, deliver && m_port, m_have, m_spur, m_err, m_cmd, m_addr};
      act = {flags_now(), bus.SpuriousResp, bus.ErrTimeout, bus.OutCmd, bus.OutAddr};
      check($sformatf("rand%0d", c), act, exp);

      if (bus.RespValid && !deliver) m_spur = 1;
      if (!m_have) begin
        if (pick_ok) begin
          m_have = 1; m_sent = 0; m_port = pick; m_prefer = !pick;
          m_cmd  = pick ? bus.InCmd1 : bus.InCmd0;
          m_addr = pick ? bus.InAddr1 : bus.InAddr0;
        end
      end else if (!m_sent) begin
        if (bus.OutCmdReady) begin
          if (m_cmd != ReadCmd || bus.RespValid) m_have = 0;
          else begin m_sent = 1; m_wait = 0; end
        end
      end else begin
        if (bus.RespValid) m_have = 0;
        else begin
          m_wait++;
`ifdef ORAM_ARB_TIMEOUT_EN
          if (m_wait == TimeoutCycles) begin m_err = 1; m_have = 0; end
`endif
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
